// File: rtl/cadder_pkg.sv
// Shared definitions for the packed complex adder pipeline.
//   op_e      : operation encoding carried on the 2-bit op port
//   range_e   : where a widened result sits relative to a signed range
//   sat_range : classifies a sign-extended result against a DATA_W-bit range
package cadder_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_ACC  = 2'b10,
        OP_LOAD = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        RNG_OK = 2'b00,  // representable in w bits
        RNG_HI = 2'b01,  // above signed max
        RNG_LO = 2'b10   // below signed min
    } range_e;

    // Widest component the classifier supports (DATA_W must be <= MAX_W).
    localparam int MAX_W = 63;

    localparam logic signed [MAX_W:0] ONE = {{MAX_W{1'b0}}, 1'b1};

    // Overflow / saturation direction of a sign-extended wide value against
    // the signed range [-2^(w-1), 2^(w-1)-1]. w is an elaboration constant,
    // so the bounds fold to constants in hardware.
    function automatic range_e sat_range(input logic signed [MAX_W:0] wide,
                                         input int unsigned           w);
        logic signed [MAX_W:0] hi;
        logic signed [MAX_W:0] lo;
        hi = (ONE <<< (w - 1)) - ONE;
        lo = -hi - ONE;
        if (wide > hi) return RNG_HI;
        if (wide < lo) return RNG_LO;
        return RNG_OK;
    endfunction

endpackage

// File: rtl/cadd_lane.sv
// One complex lane: combinational add / subtract / accumulate / load with
// wrap-around or saturation on each component.
//   op_i               : operation
//   a_*_i, b_*_i       : operands (B ignored for ACC and LOAD)
//   acc_*_i            : current accumulator value for this lane
//   s_*_o              : fitted result (also the next accumulator value)
//   ovf_o              : either component left the signed range
module cadd_lane
    import cadder_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int SAT    = 0
) (
    input  op_e                      op_i,
    input  logic signed [DATA_W-1:0] a_re_i,
    input  logic signed [DATA_W-1:0] a_im_i,
    input  logic signed [DATA_W-1:0] b_re_i,
    input  logic signed [DATA_W-1:0] b_im_i,
    input  logic signed [DATA_W-1:0] acc_re_i,
    input  logic signed [DATA_W-1:0] acc_im_i,
    output logic signed [DATA_W-1:0] s_re_o,
    output logic signed [DATA_W-1:0] s_im_o,
    output logic                     ovf_o
);

    localparam int XW = MAX_W + 1;
    localparam logic signed [DATA_W-1:0] MAX_V = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] MIN_V = {1'b1, {(DATA_W-1){1'b0}}};

    logic signed [DATA_W:0] wide_re;
    logic signed [DATA_W:0] wide_im;
    range_e                 rng_re;
    range_e                 rng_im;

    // NOTE: every signal written in an always_comb gets a default first, so
    // no path through the case can leave it unassigned and infer a latch.
    always_comb begin
        wide_re = '0;
        wide_im = '0;
        // One extra bit holds any sum/difference of two DATA_W values exactly.
        unique case (op_i)
            OP_ADD: begin
                wide_re = {a_re_i[DATA_W-1], a_re_i} + {b_re_i[DATA_W-1], b_re_i};
                wide_im = {a_im_i[DATA_W-1], a_im_i} + {b_im_i[DATA_W-1], b_im_i};
            end
            OP_SUB: begin
                wide_re = {a_re_i[DATA_W-1], a_re_i} - {b_re_i[DATA_W-1], b_re_i};
                wide_im = {a_im_i[DATA_W-1], a_im_i} - {b_im_i[DATA_W-1], b_im_i};
            end
            OP_ACC: begin
                wide_re = {acc_re_i[DATA_W-1], acc_re_i} + {a_re_i[DATA_W-1], a_re_i};
                wide_im = {acc_im_i[DATA_W-1], acc_im_i} + {a_im_i[DATA_W-1], a_im_i};
            end
            OP_LOAD: begin
                wide_re = {a_re_i[DATA_W-1], a_re_i};
                wide_im = {a_im_i[DATA_W-1], a_im_i};
            end
            default: ;
        endcase

        rng_re = sat_range(XW'(wide_re), DATA_W);
        rng_im = sat_range(XW'(wide_im), DATA_W);

        // Wrap mode keeps the low bits; saturate mode clamps by direction.
        s_re_o = wide_re[DATA_W-1:0];
        s_im_o = wide_im[DATA_W-1:0];
        if (SAT != 0) begin
            if (rng_re == RNG_HI) s_re_o = MAX_V;
            if (rng_re == RNG_LO) s_re_o = MIN_V;
            if (rng_im == RNG_HI) s_im_o = MAX_V;
            if (rng_im == RNG_LO) s_im_o = MIN_V;
        end

        // A loaded value is already in range; never report it.
        ovf_o = (op_i != OP_LOAD) && ((rng_re != RNG_OK) || (rng_im != RNG_OK));
    end

endmodule

// File: rtl/cadder_pipe.sv
// Multi-lane complex adder with a single output register stage and
// valid/ready handshakes on both sides.
//   clk, rst_n                : clock, asynchronous active-low reset
//   in_valid / in_ready       : input beat handshake
//   op, a_re, a_im, b_re, b_im: operation and packed operands (lane k at k*DATA_W)
//   out_valid / out_ready     : result beat handshake
//   s_re, s_im, ovf           : registered packed results and per-lane overflow
//   ovf_sticky / clr_sticky   : accumulated overflow flag and its clear
module cadder_pipe
    import cadder_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LANES  = 4,
    parameter int SAT    = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [1:0]              op,
    input  logic [LANES*DATA_W-1:0] a_re,
    input  logic [LANES*DATA_W-1:0] a_im,
    input  logic [LANES*DATA_W-1:0] b_re,
    input  logic [LANES*DATA_W-1:0] b_im,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*DATA_W-1:0] s_re,
    output logic [LANES*DATA_W-1:0] s_im,
    output logic [LANES-1:0]        ovf,
    output logic                    ovf_sticky,
    input  logic                    clr_sticky
);

    localparam int VW = LANES * DATA_W;

    op_e             op_sel;
    logic            accept;
    logic            acc_we;
    logic [VW-1:0]   lane_re,  lane_im;
    logic [LANES-1:0] lane_ovf;

    logic [VW-1:0]    s_re_q,   s_re_d,   s_im_q,   s_im_d;
    logic [VW-1:0]    acc_re_q, acc_re_d, acc_im_q, acc_im_d;
    logic [LANES-1:0] ovf_q,    ovf_d;
    logic             out_valid_q, out_valid_d;
    logic             sticky_q,    sticky_d;

    assign op_sel   = op_e'(op);
    // The output register can take a new beat when empty or being drained.
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign acc_we   = accept && ((op_sel == OP_ACC) || (op_sel == OP_LOAD));

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        cadd_lane #(
            .DATA_W (DATA_W),
            .SAT    (SAT)
        ) u_lane (
            .op_i     (op_sel),
            .a_re_i   (a_re[k*DATA_W +: DATA_W]),
            .a_im_i   (a_im[k*DATA_W +: DATA_W]),
            .b_re_i   (b_re[k*DATA_W +: DATA_W]),
            .b_im_i   (b_im[k*DATA_W +: DATA_W]),
            .acc_re_i (acc_re_q[k*DATA_W +: DATA_W]),
            .acc_im_i (acc_im_q[k*DATA_W +: DATA_W]),
            .s_re_o   (lane_re[k*DATA_W +: DATA_W]),
            .s_im_o   (lane_im[k*DATA_W +: DATA_W]),
            .ovf_o    (lane_ovf[k])
        );
    end

    always_comb begin
        out_valid_d = out_valid_q;
        s_re_d      = s_re_q;
        s_im_d      = s_im_q;
        ovf_d       = ovf_q;
        acc_re_d    = acc_re_q;
        acc_im_d    = acc_im_q;

        if (accept) begin
            out_valid_d = 1'b1;
            s_re_d      = lane_re;
            s_im_d      = lane_im;
            ovf_d       = lane_ovf;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        // The accumulator stores the fitted value, exactly what s_re/s_im show.
        if (acc_we) begin
            acc_re_d = lane_re;
            acc_im_d = lane_im;
        end

        // A new overflow wins over a simultaneous clear.
        sticky_d = (sticky_q && !clr_sticky) || (accept && (|lane_ovf));
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            s_re_q      <= '0;
            s_im_q      <= '0;
            ovf_q       <= '0;
            acc_re_q    <= '0;
            acc_im_q    <= '0;
            sticky_q    <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            s_re_q      <= s_re_d;
            s_im_q      <= s_im_d;
            ovf_q       <= ovf_d;
            acc_re_q    <= acc_re_d;
            acc_im_q    <= acc_im_d;
            sticky_q    <= sticky_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign s_re       = s_re_q;
    assign s_im       = s_im_q;
    assign ovf        = ovf_q;
    assign ovf_sticky = sticky_q;

endmodule

// File: tb/tb_cadder_pipe.sv
// Self-checking bench for cadder_pipe at DATA_W=8, LANES=2. Two instances
// (wrap and saturate) see identical stimulus; a reference model pushes
// expected beats into per-instance queues and a monitor pops them on each
// output handshake.
module tb_cadder_pipe;
    import cadder_pkg::*;

    localparam int DATA_W = 8;
    localparam int LANES  = 2;
    localparam int VW     = DATA_W * LANES;
    localparam int HI     = (1 << (DATA_W - 1)) - 1;
    localparam int LO     = -(1 << (DATA_W - 1));
    localparam int SPAN   = 1 << DATA_W;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic          clr_sticky = 1'b0;
    logic [1:0]    op = 2'b00;
    logic [VW-1:0] a_re = '0, a_im = '0, b_re = '0, b_im = '0;

    logic             in_ready   [2];
    logic             out_valid  [2];
    logic [VW-1:0]    s_re       [2];
    logic [VW-1:0]    s_im       [2];
    logic [LANES-1:0] ovf        [2];
    logic             ovf_sticky [2];

    always #5 clk = ~clk;

    cadder_pipe #(.DATA_W(DATA_W), .LANES(LANES), .SAT(0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[0]),
        .op(op), .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
        .out_valid(out_valid[0]), .out_ready(out_ready),
        .s_re(s_re[0]), .s_im(s_im[0]), .ovf(ovf[0]),
        .ovf_sticky(ovf_sticky[0]), .clr_sticky(clr_sticky)
    );

    cadder_pipe #(.DATA_W(DATA_W), .LANES(LANES), .SAT(1)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[1]),
        .op(op), .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
        .out_valid(out_valid[1]), .out_ready(out_ready),
        .s_re(s_re[1]), .s_im(s_im[1]), .ovf(ovf[1]),
        .ovf_sticky(ovf_sticky[1]), .clr_sticky(clr_sticky)
    );

    typedef struct {
        int               re [LANES];
        int               im [LANES];
        bit [LANES-1:0]   ov;
    } beat_t;

    beat_t sbq0[$];
    beat_t sbq1[$];

    int checks = 0;
    int errors = 0;

    // Reference state
    int acc_re_m [2][LANES];
    int acc_im_m [2][LANES];
    bit exp_ov = 1'b0;
    bit exp_sticky [2];

    // Stimulus operands (plain integers in [-128,127])
    int ar [LANES], ai [LANES], br [LANES], bi [LANES];

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int lane_val(input logic [VW-1:0] v, input int k);
        logic signed [DATA_W-1:0] s;
        s = v[k*DATA_W +: DATA_W];
        return int'(s);
    endfunction

    // Fit an exact integer into DATA_W bits by wrapping or clamping.
    function automatic void fit(input int v, input bit sat, output int r, output bit o);
        o = (v > HI) || (v < LO);
        r = v;
        if (sat) begin
            if (v > HI) r = HI;
            else if (v < LO) r = LO;
        end else begin
            while (r > HI) r -= SPAN;
            while (r < LO) r += SPAN;
        end
    endfunction

    // Present one cycle of stimulus, then update the model after the edge.
    task automatic drive(input bit v, input logic [1:0] o, input bit ordy, input bit clr);
        bit    take;
        beat_t e;
        int    wr, wi;
        bit    or_, oi, any;
        in_valid   = v;
        op         = o;
        out_ready  = ordy;
        clr_sticky = clr;
        for (int k = 0; k < LANES; k++) begin
            a_re[k*DATA_W +: DATA_W] = DATA_W'(ar[k]);
            a_im[k*DATA_W +: DATA_W] = DATA_W'(ai[k]);
            b_re[k*DATA_W +: DATA_W] = DATA_W'(br[k]);
            b_im[k*DATA_W +: DATA_W] = DATA_W'(bi[k]);
        end
        take = v && (!exp_ov || ordy);
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            any = 1'b0;
            if (take) begin
                for (int k = 0; k < LANES; k++) begin
                    case (o)
                        OP_ADD:  begin wr = ar[k] + br[k];          wi = ai[k] + bi[k];          end
                        OP_SUB:  begin wr = ar[k] - br[k];          wi = ai[k] - bi[k];          end
                        OP_ACC:  begin wr = acc_re_m[d][k] + ar[k]; wi = acc_im_m[d][k] + ai[k]; end
                        default: begin wr = ar[k];                  wi = ai[k];                  end
                    endcase
                    fit(wr, d == 1, e.re[k], or_);
                    fit(wi, d == 1, e.im[k], oi);
                    e.ov[k] = (o != OP_LOAD) && (or_ || oi);
                    any     = any | e.ov[k];
                    if (o == OP_ACC || o == OP_LOAD) begin
                        acc_re_m[d][k] = e.re[k];
                        acc_im_m[d][k] = e.im[k];
                    end
                end
                if (d == 0) sbq0.push_back(e);
                else        sbq1.push_back(e);
            end
            exp_sticky[d] = (exp_sticky[d] && !clr) || any;
        end
        exp_ov = take || (exp_ov && !ordy);
    endtask

    task automatic model_reset();
        exp_ov = 1'b0;
        for (int d = 0; d < 2; d++) begin
            exp_sticky[d] = 1'b0;
            for (int k = 0; k < LANES; k++) begin
                acc_re_m[d][k] = 0;
                acc_im_m[d][k] = 0;
            end
        end
        sbq0.delete();
        sbq1.delete();
    endtask

    task automatic check_zero(input string tag);
        for (int d = 0; d < 2; d++) begin
            check({tag, "_out_valid"}, int'(out_valid[d]), 0);
            check({tag, "_s_re"},      int'(s_re[d]), 0);
            check({tag, "_s_im"},      int'(s_im[d]), 0);
            check({tag, "_ovf"},       int'(ovf[d]), 0);
            check({tag, "_sticky"},    int'(ovf_sticky[d]), 0);
            check({tag, "_in_ready"},  int'(in_ready[d]), 1);
        end
    endtask

    task automatic lane_is(input string nm, input int d, input int k,
                           input int re, input int im, input int ov);
        check({nm, "_re"},  lane_val(s_re[d], k), re);
        check({nm, "_im"},  lane_val(s_im[d], k), im);
        check({nm, "_ovf"}, int'(ovf[d][k]), ov);
    endtask

    task automatic set_ops(input int ar0, ai0, br0, bi0, ar1, ai1, br1, bi1);
        ar[0] = ar0; ai[0] = ai0; br[0] = br0; bi[0] = bi0;
        ar[1] = ar1; ai[1] = ai1; br[1] = br1; bi[1] = bi1;
    endtask

    // Monitor: per-cycle handshake/sticky checks and scoreboard pops.
    initial begin : monitor
        beat_t e;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                check($sformatf("out_valid[%0d]", d), int'(out_valid[d]), int'(exp_ov));
                check($sformatf("in_ready[%0d]", d), int'(in_ready[d]), int'(!exp_ov || out_ready));
                check($sformatf("ovf_sticky[%0d]", d), int'(ovf_sticky[d]), int'(exp_sticky[d]));
                if (out_valid[d] && out_ready) begin
                    if ((d == 0 && sbq0.size() == 0) || (d == 1 && sbq1.size() == 0)) begin
                        check($sformatf("sb_empty[%0d]", d), 1, 0);
                    end else begin
                        if (d == 0) e = sbq0.pop_front();
                        else        e = sbq1.pop_front();
                        for (int k = 0; k < LANES; k++) begin
                            check($sformatf("sb_re[%0d][%0d]", d, k), lane_val(s_re[d], k), e.re[k]);
                            check($sformatf("sb_im[%0d][%0d]", d, k), lane_val(s_im[d], k), e.im[k]);
                            check($sformatf("sb_ovf[%0d][%0d]", d, k), int'(ovf[d][k]), int'(e.ov[k]));
                        end
                    end
                end
            end
        end
    end

    initial begin : main
        int n;
        model_reset();
        set_ops(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check_zero("por");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Wrapping ADD overflow on lane 0
        set_ops(100, -3, 100, 5, 0, 0, 0, 0);
        drive(1, OP_ADD, 1, 0);
        lane_is("add_wrap", 0, 0, -56, 2, 1);
        check("add_wrap_sticky", int'(ovf_sticky[0]), 1);
        lane_is("add_sat", 1, 0, 127, 2, 1);
        drive(0, OP_ADD, 1, 0);

        // Saturating SUB underflow on lane 1, clean lane 0
        set_ops(0, 0, 0, 0, -128, 10, 1, -20);
        drive(1, OP_SUB, 1, 0);
        lane_is("sub_sat_l1", 1, 1, -128, 30, 1);
        lane_is("sub_sat_l0", 1, 0, 0, 0, 0);
        lane_is("sub_wrap_l1", 0, 1, 127, 30, 1);
        drive(0, OP_ADD, 1, 0);

        // Sticky clear without overflow, then clear coinciding with overflow
        drive(0, OP_ADD, 1, 1);
        check("clr_sticky_w", int'(ovf_sticky[0]), 0);
        check("clr_sticky_s", int'(ovf_sticky[1]), 0);
        set_ops(100, -3, 100, 5, 0, 0, 0, 0);
        drive(1, OP_ADD, 1, 1);
        check("clr_vs_ovf_w", int'(ovf_sticky[0]), 1);
        check("clr_vs_ovf_s", int'(ovf_sticky[1]), 1);
        drive(0, OP_ADD, 1, 0);

        // LOAD then ACC x3 with an interleaved ADD
        set_ops(5, 5, 0, 0, 5, 5, 0, 0);
        drive(1, OP_LOAD, 1, 0);
        lane_is("load", 0, 0, 5, 5, 0);
        set_ops(3, -7, 9, 9, 3, -7, 9, 9);
        drive(1, OP_ACC, 1, 0);
        lane_is("acc1", 0, 0, 8, -2, 0);
        set_ops(3, -7, 1, 1, 3, -7, 1, 1);
        drive(1, OP_ADD, 1, 0);
        lane_is("add_mid", 0, 0, 4, -6, 0);
        drive(1, OP_ACC, 1, 0);
        lane_is("acc2", 1, 0, 11, -9, 0);
        drive(1, OP_ACC, 1, 0);
        lane_is("acc3", 0, 0, 14, -16, 0);
        drive(0, OP_ADD, 1, 0);

        // Backpressure: three stalled cycles, one beat taken, outputs held
        set_ops(10, 20, 1, 2, 0, 0, 0, 0);
        drive(1, OP_ADD, 0, 0);
        for (int c = 0; c < 2; c++) begin
            set_ops(50 + c, 60, 1, 1, 7, 7, 7, 7);
            check($sformatf("bp_in_ready_%0d", c), int'(in_ready[0]), 0);
            drive(1, OP_ADD, 0, 0);
            lane_is($sformatf("bp_hold_%0d", c), 0, 0, 11, 22, 0);
        end
        for (int c = 0; c < 4; c++) begin
            set_ops(c, -c, 2 * c, 1, -c, c, 3, -3);
            drive(1, OP_ADD, 1, 0);
            lane_is($sformatf("b2b_%0d", c), 0, 0, 3 * c, 1 - c, 0);
        end
        drive(0, OP_ADD, 1, 0);

        // Reset while a result is pending
        set_ops(9, 9, 0, 0, 9, 9, 0, 0);
        drive(1, OP_LOAD, 1, 0);
        drive(1, OP_ACC, 0, 0);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        model_reset();
        #1;
        check_zero("mid_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        set_ops(2, 2, 0, 0, 2, 2, 0, 0);
        drive(1, OP_ACC, 1, 0);
        lane_is("acc_after_rst", 0, 0, 2, 2, 0);
        lane_is("acc_after_rst_s", 1, 1, 2, 2, 0);

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < LANES; k++) begin
                ar[k] = int'($urandom_range(0, SPAN - 1)) + LO;
                ai[k] = int'($urandom_range(0, SPAN - 1)) + LO;
                br[k] = int'($urandom_range(0, SPAN - 1)) + LO;
                bi[k] = int'($urandom_range(0, SPAN - 1)) + LO;
            end
            drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                  $urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0);
        end

        // Drain with a bounded cycle budget
        n = 0;
        while ((sbq0.size() != 0 || sbq1.size() != 0) && n < 20) begin
            drive(0, OP_ADD, 1, 0);
            n++;
        end
        drive(0, OP_ADD, 1, 0);
        check("drain_q_wrap", sbq0.size(), 0);
        check("drain_q_sat", sbq1.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cadder_pipe.md
CADDER_PIPE -- requirements
Module: cadder_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning signed two's-complement width of each real/imaginary component.
REQ-002 SHALL have parameter LANES, default 4, meaning number of independent complex lanes processed per beat.
REQ-003 SHALL have parameter SAT, default 0, meaning overflow mode: 0 wrap-around, 1 saturate to signed min/max.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid  input  1  input beat valid.
REQ-007 SHALL have port in_ready  output  1  block can accept a beat this cycle.
REQ-008 SHALL have port op  input  2  operation: 00 ADD, 01 SUB, 10 ACC, 11 LOAD.
REQ-009 SHALL have ports a_re, a_im, b_re, b_im  input  LANES*DATA_W  packed operands; lane k occupies bits [k*DATA_W +: DATA_W].
REQ-010 SHALL have port out_valid  output  1  result beat valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts result.
REQ-012 SHALL have ports s_re, s_im  output  LANES*DATA_W  packed results, same lane packing.
REQ-013 SHALL have port ovf  output  LANES  per-lane overflow of the current result (either component).
REQ-014 SHALL have port ovf_sticky  output  1  OR of all accepted-beat overflows since reset or last clear.
REQ-015 SHALL have port clr_sticky  input  1  synchronous clear of ovf_sticky.

Function
REQ-016 SHALL accept a beat when in_valid && in_ready; in_ready = !out_valid || out_ready (combinational).
REQ-017 SHALL register the result of an accepted beat into s_re/s_im/ovf with out_valid=1 on the next cycle: latency exactly 1 cycle.
REQ-018 SHALL clear out_valid when out_ready=1 and no beat is accepted in that cycle; accept plus drain in one cycle keeps out_valid=1 with the new data.
REQ-019 SHALL hold s_re, s_im and ovf stable while out_valid=1 and out_ready=0.
REQ-020 SHALL compute per lane: ADD S=A+B; SUB S=A-B; ACC acc=acc+A, S=new acc; LOAD acc=A, S=A. B is ignored for ACC and LOAD.
REQ-021 SHALL keep one DATA_W real and one DATA_W imag accumulator per lane, updated only on accepted ACC/LOAD beats; ADD/SUB leave it unchanged.
REQ-022 SHALL compute each component at DATA_W+1 bits and flag overflow when the result is outside [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-023 SHALL, with SAT=0, truncate to the low DATA_W bits; with SAT=1, clamp to the signed max or min by the sign of the wide result.
REQ-024 SHALL store the final wrapped or saturated value in the accumulator, so the next ACC starts from the value shown on s_re/s_im.
REQ-025 SHALL set ovf_sticky on any accepted beat with any ovf bit set; if clr_sticky and a new overflow occur in the same cycle, ovf_sticky SHALL be 1.
REQ-026 SHALL report LOAD as never overflowing.

Reset
REQ-027 SHALL, on rst_n=0, immediately clear out_valid, s_re, s_im, ovf, ovf_sticky and all accumulators to 0, including mid-stream; an in-flight result is discarded.
REQ-028 SHALL drive in_ready=1 during and after reset, because it follows from out_valid=0.

Structure
REQ-029 SHALL place the op encoding enum (ADD, SUB, ACC, LOAD) and a signed saturate/overflow function in the shared package cadder_pkg.
REQ-030 SHALL implement per-lane arithmetic in one sub-module cadd_lane (combinational add/sub/saturate for one complex lane), instantiated LANES times by generate.

Verification (DATA_W=8, LANES=2)
REQ-031 SHALL test ADD, SAT=0, lane0 A=(100,-3), B=(100,5) -> S=(-56,2), ovf[0]=1, ovf_sticky=1 the cycle after acceptance.
REQ-032 SHALL test SUB, SAT=1, lane1 A=(-128,10), B=(1,-20) -> S=(-128,30), ovf[1]=1; lane0 (0,0)-(0,0) -> (0,0), ovf[0]=0.
REQ-033 SHALL test a sequence LOAD A=(5,5), then ACC A=(3,-7) three times -> outputs (5,5), (8,-2), (11,-9), (14,-16); an interleaved ADD does not change the accumulator.
REQ-034 SHALL test backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs held and exactly one beat accepted; out_ready=1 -> back-to-back beats at 1 per cycle with no loss or duplication.
REQ-035 SHALL test reset mid-ACC: rst_n pulsed low with out_valid=1 -> out_valid=0 and all outputs 0 without waiting for clk; a following ACC A=(2,2) -> (2,2).
REQ-036 SHALL test sticky clear: with ovf_sticky=1, assert clr_sticky with no overflow -> 0 next cycle; clr_sticky in the same cycle as an overflow beat -> stays 1.
